// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC sample scheduler: register map, CTRL/STATUS
// bit positions and the scheduler FSM state encoding.
package adc_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_SELECT    = 3'd2,
      ST_TRIGGER   = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_e;

   localparam int unsigned OFF_CTRL    = 32'h000;
   localparam int unsigned OFF_PERIOD  = 32'h004;
   localparam int unsigned OFF_CH_MASK = 32'h008;
   localparam int unsigned OFF_STATUS  = 32'h00C;
   localparam int unsigned OFF_OVR_CNT = 32'h010;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_ONESHOT = 1;
   localparam int unsigned CTRL_ERR_IE  = 2;
   localparam int unsigned CTRL_OVF_IE  = 3;
   localparam int unsigned CTRL_W       = 4;

   localparam int unsigned STS_BUSY      = 0;
   localparam int unsigned STS_CH_LSB    = 1;
   localparam int unsigned STS_ERR       = 4;
   localparam int unsigned STS_OVF       = 5;
   localparam int unsigned STS_STATE_LSB = 8;

   localparam int unsigned CH_W     = 3;
   localparam int unsigned PTR_W    = CH_W + 1;
   localparam int unsigned PERIOD_W = 24;
   localparam int unsigned OVR_W    = 16;

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// APB slave bus bundle for the ADC sample scheduler register file.
interface adc_sample_scheduler_if #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  PSEL;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/adc_ch_select.sv
// Combinational channel picker: lowest enabled channel at or above the scan
// pointer; valid is low once the pointer has passed every enabled channel.
module adc_ch_select #(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned CH_W   = 3,
   parameter int unsigned PTR_W  = 4
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [PTR_W-1:0]  ptr,
   output logic [CH_W-1:0]   ch,
   output logic              valid
);

   always_comb begin
      valid = 1'b0;
      ch    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!valid && mask[i] && (i >= 32'(ptr))) begin
            valid = 1'b1;
            ch    = CH_W'(i);
         end
      end
   end

endmodule

// File: rtl/adc_sample_scheduler.sv
// APB-programmed ADC scan scheduler: periodic rounds over the enabled channel
// mask, one conversion at a time, with done-timeout and FIFO-overflow tracking.
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_CH       = 8,
   parameter int unsigned DONE_TIMEOUT = 255
) (
   input  logic                   PCLK,
   input  logic                   PRESETn,
   adc_sample_scheduler_if.slave  apb,
   output logic                   adc_trigger,
   output logic [CH_W-1:0]        adc_channel,
   input  logic                   adc_done,
   input  logic                   fifo_full,
   output logic                   irq
);

   localparam int unsigned TO_W = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

   state_e                state_q, state_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
   logic [PERIOD_W-1:0]   period_q, period_d;
   logic [PERIOD_W-1:0]   cnt_q, cnt_d;
   logic [NUM_CH-1:0]     mask_q, mask_d;
   logic                  err_q, err_d;
   logic                  ovf_q, ovf_d;
   logic [OVR_W-1:0]      ovr_q, ovr_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d, ptr_next;
   logic [CH_W-1:0]       ch_q, ch_d, sel_ch;
   logic [TO_W-1:0]       to_q, to_d;
   logic                  sel_valid;
   logic                  trig;
   logic                  en;
   logic                  wr_en, rd_en, mapped;
   logic                  hit_ctrl, hit_period, hit_mask, hit_status, hit_ovr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  unused_wdata;

   assign unused_wdata = ^apb.PWDATA;

   assign wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign rd_en      = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
   assign hit_ctrl   = (apb.PADDR == ADDR_WIDTH'(OFF_CTRL));
   assign hit_period = (apb.PADDR == ADDR_WIDTH'(OFF_PERIOD));
   assign hit_mask   = (apb.PADDR == ADDR_WIDTH'(OFF_CH_MASK));
   assign hit_status = (apb.PADDR == ADDR_WIDTH'(OFF_STATUS));
   assign hit_ovr    = (apb.PADDR == ADDR_WIDTH'(OFF_OVR_CNT));
   assign mapped     = hit_ctrl | hit_period | hit_mask | hit_status | hit_ovr;

   assign en       = ctrl_q[CTRL_EN];
   assign ptr_next = PTR_W'(ch_q) + PTR_W'(1);

   adc_ch_select #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .PTR_W  (PTR_W)
   ) u_ch_select (
      .mask  (mask_q),
      .ptr   (ptr_q),
      .ch    (sel_ch),
      .valid (sel_valid)
   );

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      ovr_d    = ovr_q;
      ptr_d    = ptr_q;
      ch_d     = ch_q;
      to_d     = to_q;
      trig     = 1'b0;

      if (wr_en) begin
         if (hit_ctrl)   ctrl_d   = apb.PWDATA[CTRL_W-1:0];
         if (hit_period) period_d = apb.PWDATA[PERIOD_W-1:0];
         if (hit_mask)   mask_d   = apb.PWDATA[NUM_CH-1:0];
         if (hit_ovr)    ovr_d    = '0;
         if (hit_status) begin
            if (apb.PWDATA[STS_ERR]) err_d = 1'b0;
            if (apb.PWDATA[STS_OVF]) ovf_d = 1'b0;
         end
      end

      // Hardware updates follow the software writes so that a coincident
      // set of err/ovf (or an OVR_CNT increment) takes priority.
      unique case (state_q)
         ST_IDLE: begin
            if (en && (mask_q != '0)) begin
               cnt_d   = period_q;
               state_d = ST_WAIT_TICK;
            end
         end
         ST_WAIT_TICK: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               ptr_d   = '0;
               state_d = ST_SELECT;
            end else begin
               cnt_d = cnt_q - PERIOD_W'(1);
            end
         end
         ST_SELECT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (sel_valid) begin
               ch_d    = sel_ch;
               state_d = ST_TRIGGER;
            end else if (ctrl_q[CTRL_ONESHOT]) begin
               ctrl_d[CTRL_EN] = 1'b0;
               state_d         = ST_IDLE;
            end else begin
               cnt_d   = period_q;
               state_d = ST_WAIT_TICK;
            end
         end
         ST_TRIGGER: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (fifo_full) begin
               ovf_d = 1'b1;
               if (ovr_d != '1) ovr_d = ovr_d + OVR_W'(1);
               ptr_d   = ptr_next;
               state_d = ST_SELECT;
            end else begin
               trig    = 1'b1;
               to_d    = '0;
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (adc_done || (to_q == TO_LAST)) begin
               if (!adc_done) err_d = 1'b1;
               ptr_d   = ptr_next;
               state_d = en ? ST_SELECT : ST_IDLE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         period_q <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         ovr_q    <= '0;
         ptr_q    <= '0;
         ch_q     <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         ovr_q    <= ovr_d;
         ptr_q    <= ptr_d;
         ch_q     <= ch_d;
         to_q     <= to_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (hit_ctrl)   rdata[CTRL_W-1:0]   = ctrl_q;
      if (hit_period) rdata[PERIOD_W-1:0] = period_q;
      if (hit_mask)   rdata[NUM_CH-1:0]   = mask_q;
      if (hit_ovr)    rdata[OVR_W-1:0]    = ovr_q;
      if (hit_status) begin
         rdata[STS_BUSY]              = (state_q != ST_IDLE);
         rdata[STS_CH_LSB +: CH_W]    = ch_q;
         rdata[STS_ERR]               = err_q;
         rdata[STS_OVF]               = ovf_q;
         rdata[STS_STATE_LSB +: 3]    = state_q;
      end
   end

   assign apb.PRDATA  = rd_en ? rdata : '0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped;

   assign adc_trigger = trig;
   assign adc_channel = ch_q;
   assign irq = (err_q & ctrl_q[CTRL_ERR_IE]) | (ovf_q & ctrl_q[CTRL_OVF_IE]);

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Self-checking bench for adc_sample_scheduler: register table, randomized
// scan rounds against a timing/ordering model, and directed corner sequences.
module tb_adc_sample_scheduler;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       adc_trigger;
   logic [2:0] adc_channel;
   logic       adc_done;
   logic       fifo_full = 1'b0;
   logic       irq;
   logic       resp_done = 1'b0;
   logic       manual_done = 1'b0;
   int         resp_delay = 3;
   bit         resp_en = 1'b0;

   int checks = 0;
   int failures = 0;

   assign adc_done = resp_done | manual_done;

   adc_sample_scheduler_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) apb ();

   adc_sample_scheduler #(
      .ADDR_WIDTH   (12),
      .DATA_WIDTH   (32),
      .NUM_CH       (8),
      .DONE_TIMEOUT (255)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .apb         (apb),
      .adc_trigger (adc_trigger),
      .adc_channel (adc_channel),
      .adc_done    (adc_done),
      .fifo_full   (fifo_full),
      .irq         (irq)
   );

   always #5 PCLK = ~PCLK;

   // Event log: cycle index and channel of every trigger, and irq rising cycles.
   int   cyc = 0;
   int   trig_cyc[$];
   int   trig_ch[$];
   int   irq_rises[$];
   logic irq_prev = 1'b0;

   always @(negedge PCLK) begin
      cyc      <= cyc + 1;
      irq_prev <= irq;
      if (adc_trigger) begin
         trig_cyc.push_back(cyc);
         trig_ch.push_back(int'(adc_channel));
      end
      if (irq && !irq_prev) irq_rises.push_back(cyc);
   end

   // ADC model: completes each conversion resp_delay cycles after its trigger.
   always begin
      @(negedge PCLK);
      if (adc_trigger && resp_en) begin
         repeat (resp_delay) @(posedge PCLK);
         #1 resp_done = 1'b1;
         @(posedge PCLK);
         #1 resp_done = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
      @(posedge PCLK);
      #1 apb.PSEL = 1'b1; apb.PADDR = a; apb.PWRITE = 1'b1; apb.PWDATA = d; apb.PENABLE = 1'b0;
      @(posedge PCLK);
      #1 apb.PENABLE = 1'b1;
      #3 err = apb.PSLVERR;
      @(posedge PCLK);
      #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
      @(posedge PCLK);
      #1 apb.PSEL = 1'b1; apb.PADDR = a; apb.PWRITE = 1'b0; apb.PENABLE = 1'b0;
      @(posedge PCLK);
      #1 apb.PENABLE = 1'b1;
      #3 d = apb.PRDATA; err = apb.PSLVERR;
      @(posedge PCLK);
      #1 apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      logic e;
      apb_write(a, d, e);
   endtask

   task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic e;
      apb_read(a, d, e);
      check(name, d, exp);
   endtask

   task automatic wait_trig(input int target, input int max_cyc);
      for (int c = 0; c < max_cyc; c++) begin
         if (trig_ch.size() >= target) break;
         @(negedge PCLK);
      end
   endtask

   task automatic wait_idle(input string name, input int max_polls);
      logic [31:0] d;
      logic e;
      bit idle = 1'b0;
      for (int p = 0; p < max_polls && !idle; p++) begin
         apb_read(12'h00C, d, e);
         idle = (d[0] == 1'b0);
      end
      check(name, 32'(idle), 32'd1);
   endtask

   // Reference: channels fire in ascending mask order every round; a conversion
   // costs trigger + delay wait cycles + one select before the next trigger, and
   // a new round adds one select and PERIOD+1 tick cycles.
   task automatic run_scan(input logic [7:0] mask, input int period, input int delay, input int rounds);
      int exp_ch[$];
      int base, need, n, gap;
      for (int c = 0; c < 8; c++) if (mask[c]) exp_ch.push_back(c);
      n          = exp_ch.size();
      need       = n * rounds;
      resp_delay = delay;
      resp_en    = 1'b1;
      wr(12'h004, 32'(period));
      wr(12'h008, 32'(mask));
      base = trig_ch.size();
      wr(12'h000, 32'h1);
      wait_trig(base + need, 3000);
      check($sformatf("scan_reached m=%0h", mask), 32'(trig_ch.size() >= base + need), 32'd1);
      for (int i = 0; i < need; i++) begin
         if (base + i < trig_ch.size()) begin
            check($sformatf("scan_ch m=%0h i=%0d", mask, i), trig_ch[base + i], exp_ch[i % n]);
            if (i > 0) begin
               gap = ((i % n) == 0) ? delay + period + 4 : delay + 2;
               check($sformatf("scan_gap m=%0h p=%0d d=%0d i=%0d", mask, period, delay, i),
                     trig_cyc[base + i] - trig_cyc[base + i - 1], gap);
            end
         end
      end
      wr(12'h000, 32'h0);
      wait_idle("scan_stop_idle", 200);
      resp_en = 1'b0;
   endtask

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] d;
      logic        e;
      int          base, ibase;

      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      apb.PADDR = '0; apb.PWDATA = '0;

      vecs[0]  = '{12'h004, 1'b1, 32'h1234_5678, 32'h0,         1'b0};
      vecs[1]  = '{12'h004, 1'b0, 32'h0,         32'h0034_5678, 1'b0};
      vecs[2]  = '{12'h008, 1'b1, 32'hFFFF_FF5A, 32'h0,         1'b0};
      vecs[3]  = '{12'h008, 1'b0, 32'h0,         32'h0000_005A, 1'b0};
      vecs[4]  = '{12'h000, 1'b1, 32'hFFFF_FFFE, 32'h0,         1'b0};
      vecs[5]  = '{12'h000, 1'b0, 32'h0,         32'h0000_000E, 1'b0};
      vecs[6]  = '{12'h00C, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[7]  = '{12'h010, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[8]  = '{12'h014, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b1};
      vecs[9]  = '{12'h014, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[10] = '{12'h003, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[11] = '{12'h808, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[12] = '{12'h000, 1'b1, 32'h0,         32'h0,         1'b0};
      vecs[13] = '{12'h000, 1'b0, 32'h0,         32'h0,         1'b0};

      // Reset values while PRESETn is held low.
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_trigger", 32'(adc_trigger), 32'd0);
      check("rst_channel", 32'(adc_channel), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_prdata", apb.PRDATA, 32'd0);
      check("rst_pslverr", 32'(apb.PSLVERR), 32'd0);
      check("rst_pready", 32'(apb.PREADY), 32'd1);
      PRESETn = 1'b1;
      rd_check("rst_status", 12'h00C, 32'h0);
      rd_check("rst_ctrl", 12'h000, 32'h0);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) begin
            apb_write(vecs[i].addr, vecs[i].wdata, e);
            check($sformatf("vec%0d_werr", i), 32'(e), 32'(vecs[i].exp_err));
         end else begin
            apb_read(vecs[i].addr, d, e);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
            check($sformatf("vec%0d_rerr", i), 32'(e), 32'(vecs[i].exp_err));
         end
      end

      run_scan(8'h05, 4, 3, 2);
      for (int k = 0; k < 6; k++)
         run_scan(8'($urandom_range(1, 255)), $urandom_range(0, 6), $urandom_range(1, 5), 2);

      // One-shot round on channel 7.
      resp_delay = 2;
      resp_en    = 1'b1;
      base = trig_ch.size();
      wr(12'h004, 32'd1);
      wr(12'h008, 32'h80);
      wr(12'h000, 32'h3);
      wait_idle("os_idle", 100);
      resp_en = 1'b0;
      check("os_count", trig_ch.size() - base, 32'd1);
      if (trig_ch.size() > base) check("os_ch", trig_ch[base], 32'd7);
      rd_check("os_ctrl", 12'h000, 32'h2);
      rd_check("os_status", 12'h00C, 32'h0000_000E);

      // FIFO full for a whole one-shot round: both channels skipped.
      fifo_full = 1'b1;
      base = trig_ch.size();
      wr(12'h004, 32'd0);
      wr(12'h008, 32'h03);
      wr(12'h000, 32'hB);
      wait_idle("ovf_idle", 100);
      check("ovf_no_trig", trig_ch.size() - base, 32'd0);
      rd_check("ovf_cnt", 12'h010, 32'd2);
      rd_check("ovf_status", 12'h00C, 32'h22);
      check("ovf_irq", 32'(irq), 32'd1);
      wr(12'h00C, 32'h20);
      rd_check("ovf_w1c", 12'h00C, 32'h02);
      check("ovf_irq_clr", 32'(irq), 32'd0);
      fifo_full = 1'b0;
      wr(12'h010, 32'h1234);
      rd_check("ovr_clear", 12'h010, 32'd0);

      // Done never returned: timeout at 255 wait cycles, then next channel.
      resp_en = 1'b0;
      base  = trig_ch.size();
      ibase = irq_rises.size();
      wr(12'h008, 32'h03);
      wr(12'h000, 32'h7);
      wait_trig(base + 2, 700);
      check("to_reached", 32'(trig_ch.size() >= base + 2), 32'd1);
      if (trig_ch.size() >= base + 2) begin
         check("to_ch0", trig_ch[base], 32'd0);
         check("to_ch1", trig_ch[base + 1], 32'd1);
         check("to_gap", trig_cyc[base + 1] - trig_cyc[base], 32'd257);
      end
      check("to_irq_rose", 32'(irq_rises.size() > ibase), 32'd1);
      if (irq_rises.size() > ibase && trig_cyc.size() > base)
         check("to_irq_cycle", irq_rises[ibase] - trig_cyc[base], 32'd256);
      wait_idle("to_idle", 300);
      rd_check("to_status", 12'h00C, 32'h12);
      check("to_irq", 32'(irq), 32'd1);
      wr(12'h00C, 32'h10);
      rd_check("to_w1c", 12'h00C, 32'h02);
      check("to_irq_clr", 32'(irq), 32'd0);

      // en cleared during WAIT_DONE: conversion completes, then idle.
      base = trig_ch.size();
      wr(12'h004, 32'd2);
      wr(12'h008, 32'h01);
      wr(12'h000, 32'h1);
      wait_trig(base + 1, 100);
      check("dis_trig", trig_ch.size() - base, 32'd1);
      wr(12'h000, 32'h0);
      rd_check("dis_still_waiting", 12'h00C, 32'h401);
      repeat (10) @(posedge PCLK);
      #1 manual_done = 1'b1;
      @(posedge PCLK);
      #1 manual_done = 1'b0;
      rd_check("dis_idle", 12'h00C, 32'h0);
      repeat (30) @(posedge PCLK);
      check("dis_no_more_trig", trig_ch.size() - base, 32'd1);
      apb_read(12'h020, d, e);
      check("unmapped_rdata", d, 32'h0);
      check("unmapped_slverr", 32'(e), 32'd1);

      // Reset during WAIT_DONE with err/irq pending, then a stray done.
      base = trig_ch.size();
      wr(12'h004, 32'd0);
      wr(12'h008, 32'h10);
      wr(12'h000, 32'h5);
      wait_trig(base + 2, 400);
      check("rstw_reached", 32'(trig_ch.size() >= base + 2), 32'd1);
      rd_check("rstw_pre_status", 12'h00C, 32'h419);
      check("rstw_pre_irq", 32'(irq), 32'd1);
      check("rstw_pre_ch", 32'(adc_channel), 32'd4);
      #2 PRESETn = 1'b0;
      #1;
      check("rstw_trigger", 32'(adc_trigger), 32'd0);
      check("rstw_channel", 32'(adc_channel), 32'd0);
      check("rstw_irq", 32'(irq), 32'd0);
      check("rstw_prdata", apb.PRDATA, 32'd0);
      check("rstw_pslverr", 32'(apb.PSLVERR), 32'd0);
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      repeat (2) @(posedge PCLK);
      #1 manual_done = 1'b1;
      @(posedge PCLK);
      #1 manual_done = 1'b0;
      repeat (5) @(posedge PCLK);
      rd_check("rstw_status", 12'h00C, 32'h0);
      rd_check("rstw_ctrl", 12'h000, 32'h0);
      rd_check("rstw_mask", 12'h008, 32'h0);
      check("rstw_no_trig", trig_ch.size() - base, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
